// File: rtl/countdown_timer_ctrl.sv
// Run/pause/clear controller for a 1 Hz countdown: a prescaler divides clk down to
// one tick per second and a seconds register counts down from a loaded value.
module countdown_timer_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned SEC_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             load_en,
  input  logic [SEC_W-1:0] load_val,
  output logic [SEC_W-1:0] seconds,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             alarm
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pre, pre_n;
  logic [SEC_W-1:0] sec_n;
  logic             tick_n, done_n, wrap, last;

  always_comb begin
    state_n = state;
    pre_n   = pre;
    sec_n   = seconds;
    tick_n  = 1'b0;
    done_n  = 1'b0;
    wrap    = (state == RUN) && (pre == PRE_MAX);
    last    = (seconds == SEC_W'(1));
    if (clear) begin
      state_n = IDLE;
      sec_n   = '0;
      pre_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_en) begin
            sec_n = load_val;
            pre_n = '0;
          end else if (!pause && start && (seconds != '0)) begin
            state_n = RUN;
            pre_n   = '0;
          end
        end
        RUN: begin
          pre_n = wrap ? '0 : pre + 1'b1;
          if (wrap) begin
            sec_n  = seconds - 1'b1;
            tick_n = 1'b1;
            if (last) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
          // A pause coinciding with the final wrap still lands in DONE.
          if (!load_en && pause && !(wrap && last)) state_n = PAUSE;
        end
        PAUSE: begin
          if (load_en) begin
            state_n = IDLE;
            sec_n   = load_val;
            pre_n   = '0;
          end else if (!pause && start) begin
            state_n = RUN;
          end
        end
        DONE: begin
          if (load_en) begin
            state_n = IDLE;
            sec_n   = load_val;
            pre_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre     <= '0;
      seconds <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      seconds <= sec_n;
      tick    <= tick_n;
      done    <= done_n;
      running <= (state_n == RUN);
      alarm   <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: a cycle model pushes expected outputs into
// a queue as each stimulus cycle is driven; they are popped and compared after the edge.
module tb_countdown_timer_ctrl;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst, start, pause, clear, load_en;
  logic [7:0] load_val;
  logic [7:0] seconds;
  logic       tick, running, done, alarm;

  countdown_timer_ctrl #(.TICKS_PER_SEC(T), .SEC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .load_en(load_en), .load_val(load_val), .seconds(seconds), .tick(tick),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sec;
    logic       tk, run, dn, al;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   m_st = 0, m_pre = 0, m_sec = 0;   // 0 idle, 1 run, 2 pause, 3 done
  int   tick_cnt = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic p, input logic c,
                     input logic l, input logic [7:0] v);
    logic tk, dn;
    exp_t e;
    @(negedge clk);
    rst = r; start = s; pause = p; clear = c; load_en = l; load_val = v;
    tk = 1'b0; dn = 1'b0;
    if (r || c) begin
      m_st = 0; m_pre = 0; m_sec = 0;
    end else if (m_st == 0) begin
      if (l) begin m_sec = v; m_pre = 0; end
      else if (!p && s && m_sec > 0) begin m_st = 1; m_pre = 0; end
    end else if (m_st == 1) begin
      if (m_pre == T - 1) begin
        m_pre = 0; m_sec--; tk = 1'b1;
        if (m_sec == 0) begin m_st = 3; dn = 1'b1; end
      end else m_pre++;
      if (m_st == 1 && p && !l) m_st = 2;
    end else if (m_st == 2) begin
      if (l) begin m_st = 0; m_sec = v; m_pre = 0; end
      else if (!p && s) m_st = 1;
    end else begin
      if (l) begin m_st = 0; m_sec = v; m_pre = 0; end
    end
    e.sec = 8'(m_sec); e.tk = tk; e.run = (m_st == 1); e.dn = dn; e.al = (m_st == 3);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("seconds", 32'(seconds), 32'(e.sec));
    chk("tick",    32'(tick),    32'(e.tk));
    chk("running", 32'(running), 32'(e.run));
    chk("done",    32'(done),    32'(e.dn));
    chk("alarm",   32'(alarm),   32'(e.al));
    tick_cnt += int'(tick);
    done_cnt += int'(done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_en = 1'b0; load_val = '0;

    // 1: full countdown from 3
    cyc(1, 0, 0, 0, 0, 8'd0);
    chk("reset_seconds", 32'(seconds), 0);
    chk("reset_flags", {28'd0, tick, running, done, alarm}, 0);
    cyc(0, 0, 0, 0, 1, 8'd3);
    cyc(0, 1, 0, 0, 0, 8'd0);
    chk("t1_running", 32'(running), 1);
    tick_cnt = 0; done_cnt = 0;
    idle(14);
    chk("t1_ticks", tick_cnt, 3);
    chk("t1_dones", done_cnt, 1);
    chk("t1_sec0", 32'(seconds), 0);
    chk("t1_alarm", 32'(alarm), 1);

    // 3b: start/pause in DONE are ignored
    cyc(0, 1, 0, 0, 0, 8'd0);
    cyc(0, 0, 1, 0, 0, 8'd0);
    chk("t3_done_alarm", 32'(alarm), 1);
    chk("t3_done_run", 32'(running), 0);

    // 2: pause holds prescaler, resume gives partial credit
    cyc(0, 0, 0, 1, 0, 8'd0);
    cyc(0, 0, 0, 0, 1, 8'd5);
    cyc(0, 1, 0, 0, 0, 8'd0);
    idle(1);
    cyc(0, 0, 1, 0, 0, 8'd0);
    tick_cnt = 0;
    idle(20);
    chk("t2_paused_ticks", tick_cnt, 0);
    chk("t2_paused_sec", 32'(seconds), 5);
    cyc(0, 1, 0, 0, 0, 8'd0);
    idle(1);
    chk("t2_tick_early", 32'(tick), 0);
    idle(1);
    chk("t2_resume_tick", 32'(tick), 1);
    chk("t2_resume_sec", 32'(seconds), 4);

    // 3a: start with seconds==0 ignored
    cyc(0, 0, 0, 1, 0, 8'd0);
    cyc(0, 1, 0, 0, 0, 8'd0);
    chk("t3_zero_run", 32'(running), 0);

    // 4: clear on the wrap cycle
    cyc(0, 0, 0, 0, 1, 8'd2);
    cyc(0, 1, 0, 0, 0, 8'd0);
    idle(3);
    cyc(0, 0, 0, 1, 0, 8'd0);
    chk("t4_sec", 32'(seconds), 0);
    chk("t4_tick", 32'(tick), 0);
    chk("t4_done", 32'(done), 0);

    // 5: load ignored in RUN, honoured in DONE
    cyc(0, 0, 0, 0, 1, 8'd2);
    cyc(0, 1, 0, 0, 0, 8'd0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 8'd9);
    done_cnt = 0;
    idle(6);
    chk("t5_dones", done_cnt, 1);
    chk("t5_alarm", 32'(alarm), 1);
    cyc(0, 0, 0, 0, 1, 8'd9);
    chk("t5_load_sec", 32'(seconds), 9);
    chk("t5_load_alarm", 32'(alarm), 0);

    // 6: reset mid-run
    cyc(0, 0, 0, 0, 1, 8'd5);
    cyc(0, 1, 0, 0, 0, 8'd0);
    idle(5);
    chk("t6_pre_sec", 32'(seconds), 4);
    cyc(1, 0, 0, 0, 0, 8'd0);
    chk("t6_rst_sec", 32'(seconds), 0);
    chk("t6_rst_flags", {28'd0, tick, running, done, alarm}, 0);
    cyc(0, 1, 0, 0, 0, 8'd0);
    chk("t6_start_ignored", 32'(running), 0);
    cyc(0, 0, 0, 0, 1, 8'd3);
    cyc(0, 1, 0, 0, 0, 8'd0);
    chk("t6_start_after_load", 32'(running), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
